spi_pixel_sequencer: RTL
========================

# spi_pixel_sequencer

Clock-domain controller that sequences the SPI slave shift core for the grayscale/Sobel pipeline. It synchronises the core's chip-select and word-done signals into the system clock. It captures each received pixel word into a valid/ready stream toward the filter, and feeds processed result words back to the core's transmit register through a 2-entry FIFO. One SPI frame (one chip-select assertion) carries exactly one word in each direction.

## Interface
- WORD_SIZE, 24: SPI word width in bits (one RGB pixel in, one result word out).
- FILL_WORD, 0: transmit word used when no result is queued.
- clk_i  in  1  system clock; must run at least 4x the SCK frequency.
- nreset_i  in  1  reset, asynchronous, active-low.
- cs_i  in  1  raw chip-select from the pad; high = frame active, same polarity as the core.
- rxtx_done_i  in  1  raw word-done from the SPI core (SCK domain).
- data_rx_i  in  WORD_SIZE  received word from the core; quasi-static once done is high.
- data_tx_o  out  WORD_SIZE  word presented to the core's transmit input.
- pix_o  out  WORD_SIZE  captured pixel toward the filter.
- pix_valid_o  out  1  pix_o valid.
- pix_ready_i  in  1  filter accepts pix_o.
- res_i  in  WORD_SIZE  result word from the filter.
- res_valid_i  in  1  res_i valid.
- res_ready_o  out  1  result FIFO not full.
- overrun_o  out  1  sticky: pixel captured while pix_valid_o was still pending.
- underrun_o  out  1  sticky: FILL_WORD loaded because the FIFO was empty.
- abort_cnt_o  out  8  frames ended before done, saturating.
- frame_cnt_o  out  16  completed frames, wrapping.
- err_clr_i  in  1  synchronous pulse clearing overrun_o, underrun_o and abort_cnt_o.

## Operation
- Synchronisers: 2-flop synchronisers on cs_i and rxtx_done_i, plus one history flop each. The resulting edge pulses are cs_rise, cs_fall and done_rise.
- FSM states:
  - IDLE: cs_sync low. cs_rise goes to ACTIVE.
  - ACTIVE: waiting for the word. done_rise goes to DONE. cs_fall goes to IDLE as an abort.
  - DONE: word captured, waiting for the frame to end. cs_fall goes to IDLE as a completed frame.
- Capture on the done_rise cycle:
  - pix_o <= data_rx_i and pix_valid_o <= 1.
  - If pix_valid_o && !pix_ready_i at that moment, the old pixel is overwritten and overrun_o is set.
- Pixel handshake: pix_valid_o clears on a cycle with pix_ready_i && pix_valid_o, unless a capture happens in the same cycle. Capture wins, and valid stays 1 with the new data.
- Result FIFO:
  - 2 entries. Push when res_valid_i && res_ready_o. res_ready_o = !full (combinational).
- Completed frame (cs_fall in DONE):
  - frame_cnt_o increments.
  - If the FIFO is non-empty, pop it into data_tx_o.
  - If the FIFO is empty, data_tx_o <= FILL_WORD and underrun_o is set.
  - A push and a pop in the same cycle are both honoured; occupancy is unchanged.
- Aborted frame (cs_fall in ACTIVE):
  - abort_cnt_o increments and saturates at 255.
  - No capture, no pop; data_tx_o is held so the same word is retransmitted next frame.
- data_tx_o changes only in IDLE, so it is stable for the whole active frame.
- Counters and flags:
  - err_clr_i clears overrun_o, underrun_o and abort_cnt_o. A set event in the same cycle wins over clear.
  - frame_cnt_o is not cleared by err_clr_i; it wraps 0xFFFF -> 0.

## Timing
- Reset values: data_tx_o = FILL_WORD; pix_o, pix_valid_o, overrun_o, underrun_o, abort_cnt_o and frame_cnt_o all 0. res_ready_o = 1 (FIFO empty); FSM in IDLE.
- Capture latency: pix_valid_o rises on the 3rd clk_i rising edge after rxtx_done_i is first sampled high (2 synchroniser edges + 1 register edge).
- Update latency: data_tx_o updates on the 3rd clk_i edge after cs_i is first sampled low.
- Master requirement: cs_i must stay low for at least 4 clk_i cycles between frames, so data_tx_o is settled before the next frame's first SCK falling edge.
- Master requirement: data_rx_i must be held stable from done until cs_i falls (no extra SCK edges).
- Reset mid-frame forces IDLE with the reset values. The first cs_rise after reset starts a clean frame.
- A glitch on cs_i shorter than 2 clk_i cycles may be missed entirely; this is accepted.

## Test plan
- Reset then one frame with rx = 0xA1B2C3 and empty FIFO: pix_o = 0xA1B2C3 with valid 3 clocks after done. After cs falls, data_tx_o = FILL_WORD, underrun_o = 1 and frame_cnt_o = 1.
- Push results 0x111111 and 0x222222, then run 3 frames:
  - data_tx_o sequence after each frame is 0x111111, 0x222222, FILL_WORD.
  - res_ready_o = 0 while the FIFO holds 2 entries.
- pix_ready_i held low over 2 frames (0x000010, 0x000020): pix_o = 0x000020 and overrun_o = 1. Then err_clr_i clears the flag.
- cs falls in ACTIVE before done: abort_cnt_o = 1, frame_cnt_o unchanged, no pix_valid_o pulse, data_tx_o unchanged. The next full frame transmits the same word.
- Capture while pix_ready_i is high in the same cycle: pix_valid_o stays 1 carrying the new word. Also check a push and a pop in the same cycle leave FIFO occupancy at 1.
- nreset_i asserted in the DONE state: all outputs return to their reset values. The following frame captures correctly and frame_cnt_o = 1.

Source files
------------

// File: rtl/spi_pixel_sequencer.sv
// Sequences the SPI slave shift core: synchronises cs/done, captures received pixels into
// a valid/ready stream and feeds filter results back to the core's transmit word via a 2-deep FIFO.
module spi_pixel_sequencer #(
    parameter int unsigned          WORD_SIZE = 24,
    parameter logic [WORD_SIZE-1:0] FILL_WORD = '0
) (
    input  logic                 clk_i,
    input  logic                 nreset_i,
    input  logic                 cs_i,
    input  logic                 rxtx_done_i,
    input  logic [WORD_SIZE-1:0] data_rx_i,
    output logic [WORD_SIZE-1:0] data_tx_o,
    output logic [WORD_SIZE-1:0] pix_o,
    output logic                 pix_valid_o,
    input  logic                 pix_ready_i,
    input  logic [WORD_SIZE-1:0] res_i,
    input  logic                 res_valid_i,
    output logic                 res_ready_o,
    output logic                 overrun_o,
    output logic                 underrun_o,
    output logic [7:0]           abort_cnt_o,
    output logic [15:0]          frame_cnt_o,
    input  logic                 err_clr_i
);

    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned CNT_W      = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic cs_s1, cs_s2, cs_h;
    logic done_s1, done_s2, done_h;
    logic cs_rise_c, cs_fall_c, done_rise_c;
    logic capture_c, complete_c, abort_c;

    logic [WORD_SIZE-1:0] fifo_mem [FIFO_DEPTH];
    logic                 wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     fifo_cnt;
    logic                 fifo_full_c, fifo_empty_c, push_c, pop_c;

    // Two-flop synchronisers plus a history flop for edge detection
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            cs_s1   <= 1'b0;
            cs_s2   <= 1'b0;
            cs_h    <= 1'b0;
            done_s1 <= 1'b0;
            done_s2 <= 1'b0;
            done_h  <= 1'b0;
        end else begin
            cs_s1   <= cs_i;
            cs_s2   <= cs_s1;
            cs_h    <= cs_s2;
            done_s1 <= rxtx_done_i;
            done_s2 <= done_s1;
            done_h  <= done_s2;
        end
    end

    assign cs_rise_c   = cs_s2 & ~cs_h;
    assign cs_fall_c   = ~cs_s2 & cs_h;
    assign done_rise_c = done_s2 & ~done_h;

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) state <= S_IDLE;
        else           state <= state_nxt;
    end

    // DONE leaves on a low synchronised cs so a simultaneous done/cs_fall still completes
    always_comb begin
        state_nxt  = state;
        capture_c  = 1'b0;
        complete_c = 1'b0;
        abort_c    = 1'b0;
        case (state)
            S_IDLE: begin
                if (cs_rise_c) state_nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (done_rise_c) begin
                    state_nxt = S_DONE;
                    capture_c = 1'b1;
                end else if (cs_fall_c) begin
                    state_nxt = S_IDLE;
                    abort_c   = 1'b1;
                end
            end
            S_DONE: begin
                if (!cs_s2) begin
                    state_nxt  = S_IDLE;
                    complete_c = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign fifo_full_c  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    assign fifo_empty_c = (fifo_cnt == '0);
    assign res_ready_o  = ~fifo_full_c;
    assign push_c       = res_valid_i & ~fifo_full_c;
    assign pop_c        = complete_c & ~fifo_empty_c;

    always_ff @(posedge clk_i) begin
        if (push_c) fifo_mem[wr_ptr] <= res_i;
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= '0;
        end else begin
            if (push_c) wr_ptr <= ~wr_ptr;
            if (pop_c)  rd_ptr <= ~rd_ptr;
            case ({push_c, pop_c})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Pixel stream, transmit word, sticky flags and counters; set events win over clear
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            pix_o       <= '0;
            pix_valid_o <= 1'b0;
            overrun_o   <= 1'b0;
            underrun_o  <= 1'b0;
            data_tx_o   <= FILL_WORD;
            abort_cnt_o <= '0;
            frame_cnt_o <= '0;
        end else begin
            if (capture_c) begin
                pix_o       <= data_rx_i;
                pix_valid_o <= 1'b1;
            end else if (pix_valid_o && pix_ready_i) begin
                pix_valid_o <= 1'b0;
            end

            if (capture_c && pix_valid_o && !pix_ready_i) overrun_o <= 1'b1;
            else if (err_clr_i)                           overrun_o <= 1'b0;

            if (complete_c && fifo_empty_c) underrun_o <= 1'b1;
            else if (err_clr_i)             underrun_o <= 1'b0;

            if (complete_c) begin
                data_tx_o   <= fifo_empty_c ? FILL_WORD : fifo_mem[rd_ptr];
                frame_cnt_o <= frame_cnt_o + 16'(1);
            end

            if (abort_c) begin
                if (abort_cnt_o != 8'hFF) abort_cnt_o <= abort_cnt_o + 8'(1);
            end else if (err_clr_i) begin
                abort_cnt_o <= '0;
            end
        end
    end

endmodule
